ap_ctrl_txn_tracker: RTL and testbench
======================================

Name: ap_ctrl_txn_tracker

Overview:
- Passive, synthesizable observer on an HLS block's ap_ctrl handshake.
- Turns ap_start/ap_ready/ap_done/ap_continue activity into timestamped transaction records: id, start cycle, end cycle, latency, initiation interval.
- Sits directly upstream of the per-module status monitor/CSV dumper, which pops records through a valid/ready port.
- Never drives or stalls the observed block.

Parameters:
CNT_W, 32, width of free-running cycle counter and all timestamp/latency/II fields
ID_W, 16, width of transaction id
INFLIGHT_DEPTH, 4, max transactions started but not yet done (power of 2, >=2)
OUT_DEPTH, 4, record output FIFO depth (power of 2, >=2)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
ap_start  in  1  observed start
ap_ready  in  1  observed ready
ap_done  in  1  observed done
ap_continue  in  1  observed continue (tie 1 for non-dataflow blocks)
finish  in  1  end-of-simulation request
rec_valid  out  1  record available
rec_ready  in  1  consumer accepts record
rec_id  out  ID_W  transaction id
rec_start  out  CNT_W  cycle of start event
rec_end  out  CNT_W  cycle of done event
rec_latency  out  CNT_W  rec_end - rec_start, modulo 2^CNT_W
rec_ii  out  CNT_W  start - previous start; 0 for first transaction
inflight  out  clog2(INFLIGHT_DEPTH+1)  started-not-done count
ovf_err  out  1  sticky: dropped start or dropped record
unf_err  out  1  sticky: done with nothing in flight
drained  out  1  high in DONE state

Behaviour:
- Reset (reset==0, async): all outputs 0, cycle_cnt=0, next id=0, both FIFOs empty, no previous start, FSM=RUN.
- cycle_cnt: +1 every clock out of reset, wraps mod 2^CNT_W. Event timestamp = cycle_cnt value in the event cycle.
- Events: S = ap_start&ap_ready (RUN only). D = ap_done&ap_continue (RUN and DRAIN).
- On S with inflight FIFO not full:
  - push {id, cycle_cnt, ii}; id++ (wraps).
  - ii = cycle_cnt - last_start, or 0 if no prior start.
  - last_start updated.
- On D with inflight non-empty:
  - pop head; push record with end=cycle_cnt into output FIFO.
  - rec_valid rises the next cycle (1-cycle latency, registered FIFO, first-word-fall-through).
- S and D same cycle, inflight empty: bypass. Record uses the S entry, latency=0 (combinational HLS block). Inflight unchanged.
- S and D same cycle, inflight non-empty: pop head and push new entry together. Full FIFO does not block this case.
- S with inflight full and no simultaneous D: transaction dropped, id not incremented, last_start not updated, ovf_err=1.
- D with inflight empty and no S: no record, unf_err=1.
- D when output FIFO full and no pop that cycle: record dropped, ovf_err=1; inflight still popped.
- Output pop: rec_valid&rec_ready. Push and pop in the same cycle on a full FIFO are both allowed.
- FSM:
  - RUN -> DRAIN when finish==1 at a clock edge.
  - DRAIN: S ignored (no error); D still processed.
  - DRAIN -> DONE when inflight==0 and output FIFO empty.
  - DONE: drained=1, no further records, D ignored.
  - finish falling has no effect.
  - Only reset leaves DONE.
- Reset asserted mid-transaction discards all state immediately; sticky errors cleared.

Test Plan:
- Combinational block: S&D together at cycles 5, 6, 7 -> three records, ids 0,1,2, latency 0, ii 0,1,1, inflight stays 0.
- Pipelined: S at cycles 10, 12, 14; D at cycles 20, 22, 24 -> latencies 10,10,10, ii 0,2,2, inflight peaks 3. rec_valid high at cycle 21 for the first record.
- Overflow: 5 starts, no done, INFLIGHT_DEPTH=4 -> ovf_err=1, inflight=4, next record id 0 and fifth start absent. Consumer holds rec_ready=0 across 5 completions with OUT_DEPTH=4 -> ovf_err=1, only 4 records.
- Underflow: D with nothing in flight -> unf_err=1, rec_valid stays 0.
- Drain: 2 in flight, finish pulsed, extra S ignored, 2 D events, consumer pops 2 -> drained=1 one cycle after last pop. Later D ignored.
- Async reset mid-flight with 2 outstanding -> all outputs 0 immediately (no clock edge). After release, first start gets id 0, ii 0.

Source files
------------

// File: rtl/ap_ctrl_txn_tracker.sv
// Passive observer of an HLS ap_ctrl handshake: pairs start and done events into
// timestamped transaction records and hands them out through a FWFT record FIFO.
module ap_ctrl_txn_tracker #(
  parameter int CNT_W          = 32,
  parameter int ID_W           = 16,
  parameter int INFLIGHT_DEPTH = 4,
  parameter int OUT_DEPTH      = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 ap_start,
  input  logic                                 ap_ready,
  input  logic                                 ap_done,
  input  logic                                 ap_continue,
  input  logic                                 finish,
  output logic                                 rec_valid,
  input  logic                                 rec_ready,
  output logic [ID_W-1:0]                      rec_id,
  output logic [CNT_W-1:0]                     rec_start,
  output logic [CNT_W-1:0]                     rec_end,
  output logic [CNT_W-1:0]                     rec_latency,
  output logic [CNT_W-1:0]                     rec_ii,
  output logic [$clog2(INFLIGHT_DEPTH+1)-1:0]  inflight,
  output logic                                 ovf_err,
  output logic                                 unf_err,
  output logic                                 drained
);

  localparam int IF_AW = $clog2(INFLIGHT_DEPTH);
  localparam int IF_CW = $clog2(INFLIGHT_DEPTH + 1);
  localparam int OF_AW = $clog2(OUT_DEPTH);
  localparam int OF_CW = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             drained_q;

  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [ID_W-1:0]  next_id_q, next_id_d;
  logic [CNT_W-1:0] last_start_q, last_start_d;
  logic             have_prev_q, have_prev_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [ID_W-1:0]  if_id_q    [INFLIGHT_DEPTH];
  logic [CNT_W-1:0] if_start_q [INFLIGHT_DEPTH];
  logic [CNT_W-1:0] if_ii_q    [INFLIGHT_DEPTH];
  logic [IF_AW-1:0] if_wr_q, if_wr_d, if_rd_q, if_rd_d;
  logic [IF_CW-1:0] if_cnt_q, if_cnt_d;

  logic [ID_W-1:0]  of_id_q    [OUT_DEPTH];
  logic [CNT_W-1:0] of_start_q [OUT_DEPTH];
  logic [CNT_W-1:0] of_end_q   [OUT_DEPTH];
  logic [CNT_W-1:0] of_lat_q   [OUT_DEPTH];
  logic [CNT_W-1:0] of_ii_q    [OUT_DEPTH];
  logic [OF_AW-1:0] of_wr_q, of_wr_d, of_rd_q, of_rd_d;
  logic [OF_CW-1:0] of_cnt_q, of_cnt_d;

  logic             s_ev, d_ev, if_empty, if_full, of_full;
  logic             bypass, if_push, if_pop, rec_gen, of_push, of_pop;
  logic             drop_start, drop_rec, underflow;
  logic [CNT_W-1:0] ii_now;
  logic [ID_W-1:0]  rec_id_s;
  logic [CNT_W-1:0] rec_start_s, rec_lat_s, rec_ii_s;

  // Event decode and FIFO push/pop arbitration
  always_comb begin
    s_ev     = ap_start & ap_ready & (state_q == ST_RUN);
    d_ev     = ap_done & ap_continue & (state_q != ST_DONE);
    if_empty = (if_cnt_q == {IF_CW{1'b0}});
    if_full  = (if_cnt_q == IF_CW'(INFLIGHT_DEPTH));
    of_full  = (of_cnt_q == OF_CW'(OUT_DEPTH));

    // A start and done together with nothing outstanding is a zero-latency block.
    bypass     = s_ev & d_ev & if_empty;
    if_pop     = d_ev & ~if_empty;
    if_push    = s_ev & ~bypass & (~if_full | if_pop);
    drop_start = s_ev & ~bypass & ~if_push;
    underflow  = d_ev & if_empty & ~s_ev;
    rec_gen    = bypass | if_pop;

    of_pop   = (of_cnt_q != {OF_CW{1'b0}}) & rec_ready;
    of_push  = rec_gen & (~of_full | of_pop);
    drop_rec = rec_gen & ~of_push;

    if (have_prev_q) begin
      ii_now = cycle_cnt_q - last_start_q;
    end else begin
      ii_now = {CNT_W{1'b0}};
    end

    if (bypass) begin
      rec_id_s    = next_id_q;
      rec_start_s = cycle_cnt_q;
      rec_ii_s    = ii_now;
    end else begin
      rec_id_s    = if_id_q[if_rd_q];
      rec_start_s = if_start_q[if_rd_q];
      rec_ii_s    = if_ii_q[if_rd_q];
    end
    rec_lat_s = cycle_cnt_q - rec_start_s;
  end

  // Next-state for counters, pointers, start history and sticky errors
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    if (bypass | if_push) begin
      next_id_d    = next_id_q + {{(ID_W-1){1'b0}}, 1'b1};
      last_start_d = cycle_cnt_q;
      have_prev_d  = 1'b1;
    end else begin
      next_id_d    = next_id_q;
      last_start_d = last_start_q;
      have_prev_d  = have_prev_q;
    end

    if (if_push) begin
      if_wr_d = if_wr_q + {{(IF_AW-1){1'b0}}, 1'b1};
    end else begin
      if_wr_d = if_wr_q;
    end
    if (if_pop) begin
      if_rd_d = if_rd_q + {{(IF_AW-1){1'b0}}, 1'b1};
    end else begin
      if_rd_d = if_rd_q;
    end
    if_cnt_d = if_cnt_q + IF_CW'(if_push) - IF_CW'(if_pop);

    if (of_push) begin
      of_wr_d = of_wr_q + {{(OF_AW-1){1'b0}}, 1'b1};
    end else begin
      of_wr_d = of_wr_q;
    end
    if (of_pop) begin
      of_rd_d = of_rd_q + {{(OF_AW-1){1'b0}}, 1'b1};
    end else begin
      of_rd_d = of_rd_q;
    end
    of_cnt_d = of_cnt_q + OF_CW'(of_push) - OF_CW'(of_pop);

    ovf_d = ovf_q | drop_start | drop_rec;
    unf_d = unf_q | underflow;
  end

  // Run/drain/done sequencing; drain completes once both FIFOs will be empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (finish) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if ((if_cnt_d == {IF_CW{1'b0}}) && (of_cnt_d == {OF_CW{1'b0}})) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state and its registered drained flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drained_q <= (state_d == ST_DONE);
    end
  end

  // Counters, pointers, start history and sticky error flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q  <= {CNT_W{1'b0}};
      next_id_q    <= {ID_W{1'b0}};
      last_start_q <= {CNT_W{1'b0}};
      have_prev_q  <= 1'b0;
      if_wr_q      <= {IF_AW{1'b0}};
      if_rd_q      <= {IF_AW{1'b0}};
      if_cnt_q     <= {IF_CW{1'b0}};
      of_wr_q      <= {OF_AW{1'b0}};
      of_rd_q      <= {OF_AW{1'b0}};
      of_cnt_q     <= {OF_CW{1'b0}};
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      next_id_q    <= next_id_d;
      last_start_q <= last_start_d;
      have_prev_q  <= have_prev_d;
      if_wr_q      <= if_wr_d;
      if_rd_q      <= if_rd_d;
      if_cnt_q     <= if_cnt_d;
      of_wr_q      <= of_wr_d;
      of_rd_q      <= of_rd_d;
      of_cnt_q     <= of_cnt_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  // In-flight entry storage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < INFLIGHT_DEPTH; i++) begin
        if_id_q[i]    <= {ID_W{1'b0}};
        if_start_q[i] <= {CNT_W{1'b0}};
        if_ii_q[i]    <= {CNT_W{1'b0}};
      end
    end else if (if_push) begin
      if_id_q[if_wr_q]    <= next_id_q;
      if_start_q[if_wr_q] <= cycle_cnt_q;
      if_ii_q[if_wr_q]    <= ii_now;
    end else begin
      if_id_q[if_wr_q]    <= if_id_q[if_wr_q];
      if_start_q[if_wr_q] <= if_start_q[if_wr_q];
      if_ii_q[if_wr_q]    <= if_ii_q[if_wr_q];
    end
  end

  // Completed-record storage; zeroed on reset so idle outputs read 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        of_id_q[i]    <= {ID_W{1'b0}};
        of_start_q[i] <= {CNT_W{1'b0}};
        of_end_q[i]   <= {CNT_W{1'b0}};
        of_lat_q[i]   <= {CNT_W{1'b0}};
        of_ii_q[i]    <= {CNT_W{1'b0}};
      end
    end else if (of_push) begin
      of_id_q[of_wr_q]    <= rec_id_s;
      of_start_q[of_wr_q] <= rec_start_s;
      of_end_q[of_wr_q]   <= cycle_cnt_q;
      of_lat_q[of_wr_q]   <= rec_lat_s;
      of_ii_q[of_wr_q]    <= rec_ii_s;
    end else begin
      of_id_q[of_wr_q]    <= of_id_q[of_wr_q];
      of_start_q[of_wr_q] <= of_start_q[of_wr_q];
      of_end_q[of_wr_q]   <= of_end_q[of_wr_q];
      of_lat_q[of_wr_q]   <= of_lat_q[of_wr_q];
      of_ii_q[of_wr_q]    <= of_ii_q[of_wr_q];
    end
  end

  assign rec_valid   = (of_cnt_q != {OF_CW{1'b0}});
  assign rec_id      = of_id_q[of_rd_q];
  assign rec_start   = of_start_q[of_rd_q];
  assign rec_end     = of_end_q[of_rd_q];
  assign rec_latency = of_lat_q[of_rd_q];
  assign rec_ii      = of_ii_q[of_rd_q];
  assign inflight    = if_cnt_q;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;
  assign drained     = drained_q;

endmodule

// File: tb/tb_ap_ctrl_txn_tracker.sv
// Randomized bench for ap_ctrl_txn_tracker against a queue-based transaction model.
module tb_ap_ctrl_txn_tracker;

  localparam int CNT_W = 32;
  localparam int ID_W  = 16;
  localparam int IF_D  = 4;
  localparam int OF_D  = 4;

  logic clock = 1'b0;
  logic reset;
  logic ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready;
  logic rec_valid, ovf_err, unf_err, drained;
  logic [ID_W-1:0]  rec_id;
  logic [CNT_W-1:0] rec_start, rec_end, rec_latency, rec_ii;
  logic [$clog2(IF_D+1)-1:0] inflight;

  ap_ctrl_txn_tracker #(.CNT_W(CNT_W), .ID_W(ID_W), .INFLIGHT_DEPTH(IF_D), .OUT_DEPTH(OF_D)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_id(rec_id),
    .rec_start(rec_start), .rec_end(rec_end), .rec_latency(rec_latency),
    .rec_ii(rec_ii), .inflight(inflight), .ovf_err(ovf_err),
    .unf_err(unf_err), .drained(drained)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] st;
    logic [CNT_W-1:0] ii;
  } ent_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] st;
    logic [CNT_W-1:0] en;
    logic [CNT_W-1:0] lat;
    logic [CNT_W-1:0] ii;
  } rec_t;

  // Reference model: transactions as queues, mode 0=run 1=drain 2=done
  ent_t             m_inf[$];
  rec_t             m_out[$];
  logic [CNT_W-1:0] m_cyc, m_last;
  logic [ID_W-1:0]  m_id;
  bit               m_has_prev, m_ovf, m_unf;
  int               m_mode;

  int n_checks = 0;
  int n_fail   = 0;
  int p_start, p_ready, p_done, p_cont, p_rready;
  bit fin_req = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inf.delete();
    m_out.delete();
    m_cyc = '0; m_last = '0; m_id = '0;
    m_has_prev = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_mode = 0;
  endtask

  task automatic model_step(input bit st, input bit rd, input bit dn, input bit ct,
                            input bit fin, input bit rr);
    bit s, d, has_rec;
    logic [CNT_W-1:0] ii;
    ent_t e;
    rec_t r;
    s = st && rd && (m_mode == 0);
    d = dn && ct && (m_mode != 2);
    ii = m_has_prev ? (m_cyc - m_last) : '0;
    has_rec = 1'b0;
    r = '0;
    if (rr && m_out.size() > 0) void'(m_out.pop_front());
    if (s && d && m_inf.size() == 0) begin
      r = '{id: m_id, st: m_cyc, en: m_cyc, lat: '0, ii: ii};
      has_rec = 1'b1;
      m_id++; m_last = m_cyc; m_has_prev = 1'b1;
    end else begin
      if (d) begin
        if (m_inf.size() == 0) begin
          m_unf = 1'b1;
        end else begin
          e = m_inf.pop_front();
          r = '{id: e.id, st: e.st, en: m_cyc, lat: m_cyc - e.st, ii: e.ii};
          has_rec = 1'b1;
        end
      end
      if (s) begin
        if (m_inf.size() < IF_D) begin
          m_inf.push_back('{id: m_id, st: m_cyc, ii: ii});
          m_id++; m_last = m_cyc; m_has_prev = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (has_rec) begin
      if (m_out.size() < OF_D) m_out.push_back(r);
      else m_ovf = 1'b1;
    end
    if (m_mode == 1 && m_inf.size() == 0 && m_out.size() == 0) m_mode = 2;
    else if (m_mode == 0 && fin) m_mode = 1;
    m_cyc++;
  endtask

  task automatic compare_outputs();
    check_val("rec_valid", rec_valid, m_out.size() != 0);
    if (m_out.size() != 0) begin
      check_val("rec_id", rec_id, m_out[0].id);
      check_val("rec_start", rec_start, m_out[0].st);
      check_val("rec_end", rec_end, m_out[0].en);
      check_val("rec_latency", rec_latency, m_out[0].lat);
      check_val("rec_ii", rec_ii, m_out[0].ii);
    end
    check_val("inflight", inflight, m_inf.size());
    check_val("ovf_err", ovf_err, m_ovf);
    check_val("unf_err", unf_err, m_unf);
    check_val("drained", drained, m_mode == 2);
  endtask

  task automatic tick();
    bit st, rd, dn, ct, rr, fin;
    compare_outputs();
    st = ($urandom_range(99, 0) < p_start);
    rd = ($urandom_range(99, 0) < p_ready);
    dn = ($urandom_range(99, 0) < p_done);
    ct = ($urandom_range(99, 0) < p_cont);
    rr = ($urandom_range(99, 0) < p_rready);
    fin = fin_req;
    fin_req = 1'b0;
    ap_start = st; ap_ready = rd; ap_done = dn; ap_continue = ct;
    rec_ready = rr; finish = fin;
    model_step(st, rd, dn, ct, fin, rr);
    @(negedge clock);
  endtask

  task automatic do_async_reset();
    compare_outputs();
    #2 reset = 1'b0;
    #1;
    check_val("rst_rec_valid", rec_valid, 1'b0);
    check_val("rst_rec_id", rec_id, '0);
    check_val("rst_rec_start", rec_start, '0);
    check_val("rst_rec_latency", rec_latency, '0);
    check_val("rst_inflight", inflight, '0);
    check_val("rst_ovf_err", ovf_err, 1'b0);
    check_val("rst_unf_err", unf_err, 1'b0);
    check_val("rst_drained", drained, 1'b0);
    model_reset();
    ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b0;
    finish = 1'b0; rec_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic set_profile(input int kind);
    case (kind)
      0: begin p_start = 90; p_ready = 100; p_done = 90; p_cont = 100; p_rready = 100; end
      1: begin p_start = 40; p_ready = 70;  p_done = 40; p_cont = 80;  p_rready = 70;  end
      2: begin p_start = 70; p_ready = 90;  p_done = 5;  p_cont = 100; p_rready = 5;   end
      default: begin p_start = 10; p_ready = 100; p_done = 60; p_cont = 100; p_rready = 100; end
    endcase
  endtask

  initial begin
    reset = 1'b0;
    ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b0;
    finish = 1'b0; rec_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;

    for (int ph = 0; ph < 12; ph++) begin
      set_profile(ph % 4);
      repeat (150) tick();
      if (ph == 5 || ph == 9) do_async_reset();
    end

    // Drain: further starts must be ignored while outstanding work completes
    set_profile(1);
    p_start = 60; p_done = 50; p_cont = 100; p_rready = 90;
    fin_req = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (m_mode == 2) break;
    end
    check_val("drained_reached", drained, 1'b1);
    p_done = 80;
    repeat (20) tick();
    check_val("done_no_record", rec_valid, 1'b0);

    // Reset out of DONE: tracking restarts with id 0 and ii 0
    do_async_reset();
    set_profile(0);
    repeat (40) tick();
    compare_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
